axil_rd_slave: RTL and testbench

AXI4-Lite read-channel responder: accepts read addresses on the AR channel, fetches a word from an external register bank through a simple synchronous read port, and returns it on the R channel. It is the slave-side counterpart to the master-driven AR channel and is sized so that ARREADY always arrives within the interface's maximum-wait budget. It supports one outstanding read, and out-of-range addresses complete with SLVERR.

---
 rtl/axil_rd_slave.sv | 197 +++++++++++++++++++
 tb/tb_axil_rd_slave.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_rd_slave.sv
//-----------------------------------------------------------------------------
// axil_rd_slave
//
// AXI4-Lite read-channel responder. A read address is accepted on AR after a
// fixed number of wait cycles, the addressed word is fetched from an external
// register bank through a one-cycle-latency synchronous read port, and the
// word is returned on R. One read is outstanding at a time. Addresses whose
// word index is beyond the bank complete with SLVERR and zero data, and are
// counted in a saturating error counter.
//
// Ports
//   AXI_ACLK      clock, all logic on the rising edge
//   AXI_ARESETN   synchronous active-low reset
//   AXI_ARADDR    read byte address (bits [1:0] ignored)
//   AXI_ARPROT    accepted and ignored
//   AXI_ARVALID   address valid from the master
//   AXI_ARREADY   address ready (registered)
//   AXI_RDATA     read data (registered)
//   AXI_RRESP     2'b00 OKAY / 2'b10 SLVERR (registered)
//   AXI_RVALID    read data valid (registered)
//   AXI_RREADY    master ready for read data
//   REG_RD_EN     one-cycle read strobe to the register bank
//   REG_RD_ADDR   word index presented with REG_RD_EN
//   REG_RD_DATA   bank data, valid the cycle after REG_RD_EN
//   RD_ERR_CNT    saturating count of SLVERR reads
//-----------------------------------------------------------------------------
`timescale 1ns / 1ps

module axil_rd_slave #(
  parameter int  C_AXI_DATA_WIDTH = 32,
  parameter int  C_AXI_ADDR_WIDTH = 8,
  parameter int  NUM_REGS         = 16,
  parameter int  ARREADY_DELAY    = 2,
  localparam int REG_ADDR_WIDTH   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESETN,
  input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR,
  input  logic [2:0]                  AXI_ARPROT,
  input  logic                        AXI_ARVALID,
  output logic                        AXI_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0] AXI_RDATA,
  output logic [1:0]                  AXI_RRESP,
  output logic                        AXI_RVALID,
  input  logic                        AXI_RREADY,
  output logic                        REG_RD_EN,
  output logic [REG_ADDR_WIDTH-1:0]   REG_RD_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0] REG_RD_DATA,
  output logic [7:0]                  RD_ERR_CNT
);

  localparam int                 IDX_WIDTH   = C_AXI_ADDR_WIDTH - 2;
  // One extra bit so that NUM_REGS == 2^IDX_WIDTH is representable.
  localparam logic [IDX_WIDTH:0] NUM_REGS_W  = (IDX_WIDTH + 1)'(NUM_REGS);
  localparam logic [2:0]         DELAY_W     = 3'(ARREADY_DELAY);
  localparam logic [1:0]         RESP_OKAY   = 2'b00;
  localparam logic [1:0]         RESP_SLVERR = 2'b10;

  // S_LOAD is the cycle in which the bank drives REG_RD_DATA; the word is
  // registered onto R at the end of it.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCEPT,
    S_FETCH,
    S_LOAD,
    S_RESP
  } state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  wait_cnt_q, wait_cnt_d;
  logic                        in_range_q, in_range_d;
  logic                        arready_d;
  logic                        rvalid_d;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_d;
  logic [1:0]                  rresp_d;
  logic                        rd_en_d;
  logic [REG_ADDR_WIDTH-1:0]   rd_addr_d;
  logic [7:0]                  err_cnt_d;

  logic [IDX_WIDTH-1:0]        ar_idx;
  logic                        ar_in_range;
  logic                        unused_inputs;

  assign ar_idx        = AXI_ARADDR[C_AXI_ADDR_WIDTH-1:2];
  assign ar_in_range   = ({1'b0, ar_idx} < NUM_REGS_W);
  // Protection bits and the byte offset carry no meaning for this slave.
  assign unused_inputs = ^{AXI_ARPROT, AXI_ARADDR[1:0]};

  // Next-state and next-output logic. Every output is registered below, so
  // nothing on an output port depends combinationally on an input port.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    in_range_d = in_range_q;
    arready_d  = 1'b0;
    rvalid_d   = AXI_RVALID;
    rdata_d    = AXI_RDATA;
    rresp_d    = AXI_RRESP;
    rd_en_d    = 1'b0;
    rd_addr_d  = REG_RD_ADDR;
    err_cnt_d  = RD_ERR_CNT;

    case (state_q)
      S_IDLE: begin
        if (AXI_ARVALID) begin
          wait_cnt_d = '0;
          // With no wait cycles ARREADY must already be up after the edge
          // that first sees ARVALID, so WAIT is skipped.
          if (DELAY_W == 3'd0) begin
            arready_d = 1'b1;
            state_d   = S_ACCEPT;
          end else begin
            state_d   = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 3'd1;
        if (wait_cnt_d == DELAY_W) begin
          arready_d = 1'b1;
          state_d   = S_ACCEPT;
        end
      end

      S_ACCEPT: begin
        if (AXI_ARVALID) begin
          in_range_d = ar_in_range;
          rd_en_d    = ar_in_range;
          if (ar_in_range) begin
            rd_addr_d = ar_idx[REG_ADDR_WIDTH-1:0];
          end else if (RD_ERR_CNT != 8'hFF) begin
            err_cnt_d = RD_ERR_CNT + 8'd1;
          end
          state_d = S_FETCH;
        end else begin
          // Master withdrew ARVALID while ARREADY was high: no handshake.
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        rvalid_d = 1'b1;
        rdata_d  = in_range_q ? REG_RD_DATA : '0;
        rresp_d  = in_range_q ? RESP_OKAY : RESP_SLVERR;
        state_d  = S_RESP;
      end

      S_RESP: begin
        if (AXI_RREADY) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      in_range_q  <= 1'b0;
      AXI_ARREADY <= 1'b0;
      AXI_RVALID  <= 1'b0;
      AXI_RDATA   <= '0;
      AXI_RRESP   <= RESP_OKAY;
      REG_RD_EN   <= 1'b0;
      REG_RD_ADDR <= '0;
      RD_ERR_CNT  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      in_range_q  <= in_range_d;
      AXI_ARREADY <= arready_d;
      AXI_RVALID  <= rvalid_d;
      AXI_RDATA   <= rdata_d;
      AXI_RRESP   <= rresp_d;
      REG_RD_EN   <= rd_en_d;
      REG_RD_ADDR <= rd_addr_d;
      RD_ERR_CNT  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_axil_rd_slave.sv
//-----------------------------------------------------------------------------
// tb_axil_rd_slave
//
// Three instances of axil_rd_slave with ARREADY_DELAY = 0, 2 and 4 (instance
// index times two). Each has its own register-bank model with one cycle of
// read latency. The driver issues directed reads and pushes the expected R
// beat into a shared queue; a monitor pops and compares on every R handshake.
//-----------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_axil_rd_slave;

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  araddr  [3];
  logic        arvalid [3];
  logic        arready [3];
  logic [31:0] rdata   [3];
  logic [1:0]  rresp   [3];
  logic        rvalid  [3];
  logic        rready  [3];
  logic        rd_en   [3];
  logic [3:0]  rd_addr [3];
  logic [7:0]  err_cnt [3];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank contents: word 2 holds 0xDEADBEEF, word k otherwise 0x1000_0000 + k*0x101.
  function automatic logic [31:0] bank_word(input logic [3:0] k);
    if (k == 4'd2) return 32'hDEAD_BEEF;
    return 32'h1000_0000 + 32'(k) * 32'h0000_0101;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] bank_q;

    // Stale data outside the read cycle, so a mistimed capture is visible.
    always @(posedge clk) bank_q <= rd_en[g] ? bank_word(rd_addr[g]) : 32'h0BAD_F00D;

    axil_rd_slave #(
      .C_AXI_DATA_WIDTH(32),
      .C_AXI_ADDR_WIDTH(8),
      .NUM_REGS        (16),
      .ARREADY_DELAY   (2 * g)
    ) u_dut (
      .AXI_ACLK    (clk),
      .AXI_ARESETN (rst_n),
      .AXI_ARADDR  (araddr[g]),
      .AXI_ARPROT  (3'b000),
      .AXI_ARVALID (arvalid[g]),
      .AXI_ARREADY (arready[g]),
      .AXI_RDATA   (rdata[g]),
      .AXI_RRESP   (rresp[g]),
      .AXI_RVALID  (rvalid[g]),
      .AXI_RREADY  (rready[g]),
      .REG_RD_EN   (rd_en[g]),
      .REG_RD_ADDR (rd_addr[g]),
      .REG_RD_DATA (bank_q),
      .RD_ERR_CNT  (err_cnt[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are read at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every R handshake must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rvalid[i] === 1'b1 && rready[i] === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_rvalid: instance %0d presented R with nothing expected", i);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("r_inst[%0d]", i), i, e.inst);
            check($sformatf("rdata[%0d]", i), rdata[i], e.data);
            check($sformatf("rresp[%0d]", i), {30'd0, rresp[i]}, {30'd0, e.resp});
          end
        end
      end
    end
  end

  // One complete read. hold = cycles RREADY stays low once RVALID is up;
  // poke = present a second ARVALID during that window.
  task automatic do_read(input int i, input logic [7:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int hold, input bit poke);
    int          k;
    int          busy;
    logic        ok;
    logic [7:0]  cnt0;
    logic [7:0]  cnt_exp;
    exp_t        e;
    ok      = (exp_resp == 2'b00);
    cnt0    = err_cnt[i];
    cnt_exp = ok ? cnt0 : ((cnt0 == 8'hFF) ? 8'hFF : cnt0 + 8'd1);
    e.inst  = i;
    e.data  = exp_data;
    e.resp  = exp_resp;
    exp_q.push_back(e);
    rready[i]  = (hold == 0);
    araddr[i]  = addr;
    arvalid[i] = 1'b1;
    tick();                                           // E0: ARVALID sampled
    k = 0;
    while (arready[i] !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    check($sformatf("arready_delay[%0d]", i), k, 2 * i);
    check($sformatf("arready_budget[%0d]", i), {31'd0, k <= 4}, 32'd1);
    if (arready[i] !== 1'b1) begin
      arvalid[i] = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    busy = k;
    tick(); busy++;                                   // H: handshake
    arvalid[i] = 1'b0;
    check($sformatf("arready_one_cycle[%0d]", i), arready[i], 1'b0);
    check($sformatf("rd_en_after_h[%0d]", i), rd_en[i], ok);
    if (ok) check($sformatf("rd_addr[%0d]", i), rd_addr[i], addr[5:2]);
    check($sformatf("err_cnt[%0d]", i), err_cnt[i], cnt_exp);
    tick(); busy++;                                   // H+1
    check($sformatf("rd_en_one_cycle[%0d]", i), rd_en[i], 1'b0);
    check($sformatf("rvalid_early[%0d]", i), rvalid[i], 1'b0);
    tick(); busy++;                                   // H+2: R loaded
    check($sformatf("rvalid_rise[%0d]", i), rvalid[i], 1'b1);
    for (int j = 0; j < hold; j++) begin
      if (poke) begin
        araddr[i]  = 8'h04;
        arvalid[i] = 1'b1;
      end
      tick();
      check($sformatf("hold_rvalid[%0d]", i), rvalid[i], 1'b1);
      check($sformatf("hold_rdata[%0d]", i), rdata[i], exp_data);
      check($sformatf("hold_rresp[%0d]", i), {30'd0, rresp[i]}, {30'd0, exp_resp});
      if (poke) check($sformatf("no_arready_busy[%0d]", i), arready[i], 1'b0);
    end
    arvalid[i] = 1'b0;
    rready[i]  = 1'b1;
    tick(); busy++;                                   // RREADY sampled high
    check($sformatf("rvalid_fall[%0d]", i), rvalid[i], 1'b0);
    if (hold == 0) check($sformatf("busy_cycles[%0d]", i), busy, 2 * i + 4);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    logic [7:0] err_before;
    for (int i = 0; i < 3; i++) begin
      araddr[i]  = 8'h00;
      arvalid[i] = 1'b0;
      rready[i]  = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_arready", arready[1], 1'b0);
    check("rst_rvalid",  rvalid[1],  1'b0);
    check("rst_rdata",   rdata[1],   32'h0);
    check("rst_rresp",   {30'd0, rresp[1]}, 32'h0);
    check("rst_rd_en",   rd_en[1],   1'b0);
    check("rst_rd_addr", rd_addr[1], 4'h0);
    check("rst_err_cnt", err_cnt[1], 8'h00);
    rst_n = 1'b1;
    tick();

    // In-range reads, ARREADY_DELAY = 2.
    do_read(1, 8'h08, 32'hDEAD_BEEF, 2'b00, 0, 1'b0);
    do_read(1, 8'h3D, 32'h1000_0F0F, 2'b00, 0, 1'b0);   // word 15, offset ignored

    // Out-of-range reads.
    do_read(1, 8'h40, 32'h0, 2'b10, 0, 1'b0);           // word 16
    check("err_cnt_first", err_cnt[1], 8'd1);
    do_read(1, 8'hFC, 32'h0, 2'b10, 0, 1'b0);           // word 63
    check("err_cnt_second", err_cnt[1], 8'd2);

    // R backpressure with a second ARVALID during the wait.
    do_read(1, 8'h04, 32'h1000_0101, 2'b00, 6, 1'b1);

    // ARVALID withdrawn while ARREADY is high: no read, no response.
    err_before = err_cnt[1];
    araddr[1]  = 8'h40;
    arvalid[1] = 1'b1;
    tick();
    k = 0;
    while (arready[1] !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    check("drop_arready_seen", arready[1], 1'b1);
    arvalid[1] = 1'b0;
    tick();
    check("drop_no_rd_en", rd_en[1], 1'b0);
    check("drop_arready_low", arready[1], 1'b0);
    repeat (4) begin
      tick();
      check("drop_no_rvalid", rvalid[1], 1'b0);
    end
    check("drop_err_cnt", err_cnt[1], err_before);

    // Reset while the read is in FETCH.
    araddr[1]  = 8'h08;
    arvalid[1] = 1'b1;
    tick();
    k = 0;
    while (arready[1] !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    tick();                                             // handshake, now in FETCH
    arvalid[1] = 1'b0;
    check("fetch_rd_en", rd_en[1], 1'b1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_arready", arready[1], 1'b0);
    check("mid_rst_rvalid",  rvalid[1],  1'b0);
    check("mid_rst_rdata",   rdata[1],   32'h0);
    check("mid_rst_rresp",   {30'd0, rresp[1]}, 32'h0);
    check("mid_rst_rd_en",   rd_en[1],   1'b0);
    check("mid_rst_rd_addr", rd_addr[1], 4'h0);
    check("mid_rst_err_cnt", err_cnt[1], 8'h00);
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      check("post_rst_no_rvalid", rvalid[1], 1'b0);
    end
    do_read(1, 8'h08, 32'hDEAD_BEEF, 2'b00, 0, 1'b0);

    // Delay sweep, back-to-back with RREADY high.
    do_read(0, 8'h08, 32'hDEAD_BEEF, 2'b00, 0, 1'b0);
    do_read(0, 8'h00, 32'h1000_0000, 2'b00, 0, 1'b0);
    do_read(0, 8'h50, 32'h0,         2'b10, 0, 1'b0);
    do_read(2, 8'h08, 32'hDEAD_BEEF, 2'b00, 0, 1'b0);
    do_read(2, 8'h0C, 32'h1000_0303, 2'b00, 0, 1'b0);

    // Error-counter saturation.
    apply_reset();
    for (int n = 1; n <= 257; n++) begin
      do_read(1, 8'h80, 32'h0, 2'b10, 0, 1'b0);
      if (n == 1)   check("sat_err_cnt_1",   err_cnt[1], 8'd1);
      if (n == 255) check("sat_err_cnt_255", err_cnt[1], 8'd255);
      if (n == 257) check("sat_err_cnt_257", err_cnt[1], 8'd255);
    end
    do_read(1, 8'h08, 32'hDEAD_BEEF, 2'b00, 0, 1'b0);
    check("sat_hold_after_ok", err_cnt[1], 8'd255);

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
